// File: rtl/task_cmd_issuer_if.sv
// ---------------------------------------------------------------------------
// task_cmd_issuer_if
//
// Bundles the signals between the host/scheduler, the task_cmd_issuer and
// the task-block array.
//
//   req_valid / req_ready        host request handshake
//   req_task / req_opcode /      request payload (task ID, opcode, operand)
//   req_data
//   out_op                       shared 16-bit task operation bus
//   exe_flag_in                  per-task exe_flag feedback
//   busy                         issuer has work pending or in flight
//   done_valid / done_task /     one-cycle completion report
//   done_status
//
// Modports:
//   slave  - the issuer (consumes requests, drives the bus and reports)
//   master - the host/scheduler side
// ---------------------------------------------------------------------------
interface task_cmd_issuer_if #(
   parameter int NUM_TASKS = 8
);
   logic                 req_valid;
   logic                 req_ready;
   logic [3:0]           req_task;
   logic [3:0]           req_opcode;
   logic [3:0]           req_data;
   logic [15:0]          out_op;
   logic [NUM_TASKS-1:0] exe_flag_in;
   logic                 busy;
   logic                 done_valid;
   logic [3:0]           done_task;
   logic [1:0]           done_status;

   modport slave (
      input  req_valid, req_task, req_opcode, req_data, exe_flag_in,
      output req_ready, out_op, busy, done_valid, done_task, done_status
   );

   modport master (
      output req_valid, req_task, req_opcode, req_data, exe_flag_in,
      input  req_ready, out_op, busy, done_valid, done_task, done_status
   );
endinterface

// File: rtl/task_cmd_issuer.sv
// ---------------------------------------------------------------------------
// task_cmd_issuer
//
// Issuer side of the 16-bit task operation bus. Host requests are queued in
// a small FIFO and serialised onto out_op, each word held for HOLD_CYCLES
// cycles and followed by at least one idle (16'h0000) cycle. Execute (7) and
// Finish (F) commands then wait for the addressed task's exe_flag to reach
// 1 (execute) or 0 (finish) before completion is reported.
//
// Ports:
//   CLK            clock, rising edge
//   RST_N          asynchronous reset, active low
//   bus (slave)    request handshake, out_op bus, exe_flag feedback,
//                  busy and done_valid/done_task/done_status report
//
// Status codes: 00 OK, 01 TIMEOUT, 10 BAD_ID.
//
// Configuration macro:
//   TASK_ISSUER_TIMEOUT_EN  defined: WAIT gives up after EXE_TIMEOUT cycles
//                           with status TIMEOUT.
//                           undefined: WAIT blocks until the flag matches.
// ---------------------------------------------------------------------------
module task_cmd_issuer #(
   parameter int NUM_TASKS   = 8,
   parameter int HOLD_CYCLES = 2,
   parameter int FIFO_DEPTH  = 4,
   parameter int EXE_TIMEOUT = 1024
) (
   input logic              CLK,
   input logic              RST_N,
   task_cmd_issuer_if.slave bus
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

   localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [4:0]        TASK_LIMIT = 5'(NUM_TASKS);
   localparam logic [3:0]        OP_EXECUTE = 4'h7;
   localparam logic [3:0]        OP_FINISH  = 4'hF;

   // Parameter legality, caught at elaboration.
   if (NUM_TASKS < 1 || NUM_TASKS > 16) begin : g_bad_num_tasks
      $error("task_cmd_issuer: NUM_TASKS must be 1..16");
   end
   if (HOLD_CYCLES < 1) begin : g_bad_hold
      $error("task_cmd_issuer: HOLD_CYCLES must be >= 1");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("task_cmd_issuer: FIFO_DEPTH must be a power of two >= 2");
   end
   if (EXE_TIMEOUT < 1) begin : g_bad_timeout
      $error("task_cmd_issuer: EXE_TIMEOUT must be >= 1");
   end

   typedef struct packed {
      logic [3:0] task_id;
      logic [3:0] opcode;
      logic [3:0] data;
   } req_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRIVE,
      S_WAIT,
      S_REPORT
   } state_t;

   typedef enum logic [1:0] {
      ST_OK      = 2'b00,
      ST_TIMEOUT = 2'b01,
      ST_BAD_ID  = 2'b10
   } status_t;

   // -------------------------------------------------------------------------
   // Request FIFO
   // -------------------------------------------------------------------------
   req_t             fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_nxt;
   logic             full;
   logic             push;
   logic             pop;
   req_t             head;

   state_t           state;
   logic [3:0]       cur_task;
   logic [3:0]       cur_op;
   logic [HOLD_W-1:0] hold_cnt;
   logic             fsm_idle_nxt;
   logic             busy_nxt;
   logic [15:0]      flag_pad;
   logic             flag_sel;
   logic             flag_match;
   logic             head_bad_id;
   logic             cur_is_wait;

   assign full          = (count == CNT_W'(FIFO_DEPTH));
   assign bus.req_ready = !full;
   assign push          = bus.req_valid && !full;
   // The only pop point: IDLE with something queued.
   assign pop           = (state == S_IDLE) && (count != '0);
   assign head          = fifo_mem[rd_ptr];
   assign head_bad_id   = ({1'b0, head.task_id} >= TASK_LIMIT);

   // Zero-extend the feedback so any 4-bit task ID indexes it safely.
   assign flag_pad    = 16'(bus.exe_flag_in);
   assign flag_sel    = flag_pad[cur_task];
   assign flag_match  = (cur_op == OP_EXECUTE) ? flag_sel : !flag_sel;
   assign cur_is_wait = (cur_op == OP_EXECUTE) || (cur_op == OP_FINISH);

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      count_nxt = count;
      if (push && !pop) begin
         count_nxt = count + CNT_W'(1);
      end else if (pop && !push) begin
         count_nxt = count - CNT_W'(1);
      end
      // The FSM lands in IDLE next cycle only from REPORT or an idle IDLE.
      fsm_idle_nxt = (state == S_REPORT) || ((state == S_IDLE) && !pop);
      busy_nxt     = !fsm_idle_nxt || (count_nxt != '0);
   end

   // NOTE: the storage array carries no reset; wr_ptr/rd_ptr/count alone
   // decide which entries are valid, so stale contents are never observed.
   always_ff @(posedge CLK) begin
      if (push) begin
         fifo_mem[wr_ptr] <= '{task_id: bus.req_task,
                               opcode:  bus.req_opcode,
                               data:    bus.req_data};
      end
   end

   // Pointers wrap naturally because FIFO_DEPTH is a power of two.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // Optional WAIT timeout counter
   // -------------------------------------------------------------------------
`ifdef TASK_ISSUER_TIMEOUT_EN
   localparam int TO_W = $clog2(EXE_TIMEOUT + 1);
   logic [TO_W-1:0] wait_cnt;
   logic [TO_W-1:0] wait_cnt_inc;
   // Count including the current WAIT cycle.
   assign wait_cnt_inc = wait_cnt + TO_W'(1);
`endif

   // -------------------------------------------------------------------------
   // Issue FSM with registered outputs
   // -------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state           <= S_IDLE;
         cur_task        <= '0;
         cur_op          <= '0;
         hold_cnt        <= '0;
         bus.out_op      <= 16'h0000;
         bus.busy        <= 1'b0;
         bus.done_valid  <= 1'b0;
         bus.done_task   <= '0;
         bus.done_status <= ST_OK;
`ifdef TASK_ISSUER_TIMEOUT_EN
         wait_cnt        <= '0;
`endif
      end else begin
         // NOTE: non-blocking assignments throughout; every branch below
         // reads the pre-edge values, so ordering inside the block is free.
         bus.busy       <= busy_nxt;
         bus.done_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (pop) begin
                  cur_task <= head.task_id;
                  cur_op   <= head.opcode;
                  if (head_bad_id) begin
                     // Nothing is driven on the bus for an unknown task.
                     bus.done_valid  <= 1'b1;
                     bus.done_task   <= head.task_id;
                     bus.done_status <= ST_BAD_ID;
                     state           <= S_REPORT;
                  end else begin
                     bus.out_op <= {4'b0000, head.task_id, head.opcode, head.data};
                     hold_cnt   <= '0;
                     state      <= S_DRIVE;
                  end
               end
            end

            S_DRIVE: begin
               if (hold_cnt == HOLD_LAST) begin
                  bus.out_op <= 16'h0000;
                  if (cur_is_wait) begin
`ifdef TASK_ISSUER_TIMEOUT_EN
                     wait_cnt <= '0;
`endif
                     state <= S_WAIT;
                  end else begin
                     bus.done_valid  <= 1'b1;
                     bus.done_task   <= cur_task;
                     bus.done_status <= ST_OK;
                     state           <= S_REPORT;
                  end
               end else begin
                  hold_cnt <= hold_cnt + HOLD_W'(1);
               end
            end

            S_WAIT: begin
               if (flag_match) begin
                  bus.done_valid  <= 1'b1;
                  bus.done_task   <= cur_task;
                  bus.done_status <= ST_OK;
                  state           <= S_REPORT;
               end
`ifdef TASK_ISSUER_TIMEOUT_EN
               else if (wait_cnt_inc == TO_W'(EXE_TIMEOUT)) begin
                  bus.done_valid  <= 1'b1;
                  bus.done_task   <= cur_task;
                  bus.done_status <= ST_TIMEOUT;
                  state           <= S_REPORT;
               end else begin
                  wait_cnt <= wait_cnt_inc;
               end
`endif
            end

            S_REPORT: begin
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_task_cmd_issuer.sv
// ---------------------------------------------------------------------------
// tb_task_cmd_issuer
//
// Self-checking bench for task_cmd_issuer. A transaction-level reference
// model (request queue plus pop/finish timestamps) predicts every output
// each cycle; directed scenarios cover the basic op, execute handshake,
// finish timeout (or blocking wait), bad ID, FIFO back-pressure and reset
// during WAIT, followed by a randomized mix.
// ---------------------------------------------------------------------------
module tb_task_cmd_issuer;

   localparam int NUM_TASKS = 8;
   localparam int HOLD      = 2;
   localparam int DEPTH     = 4;
   localparam int TMO       = 16;
`ifdef TASK_ISSUER_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic CLK   = 1'b0;
   logic RST_N = 1'b0;
   always #5 CLK = ~CLK;

   task_cmd_issuer_if #(.NUM_TASKS(NUM_TASKS)) bus ();
   logic [NUM_TASKS-1:0] flags;
   assign bus.exe_flag_in = flags;

   task_cmd_issuer #(
      .NUM_TASKS   (NUM_TASKS),
      .HOLD_CYCLES (HOLD),
      .FIFO_DEPTH  (DEPTH),
      .EXE_TIMEOUT (TMO)
   ) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus)
   );

   // ------------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------------
   typedef struct {
      logic [3:0] t;
      logic [3:0] o;
      logic [3:0] d;
   } mreq_t;

   mreq_t      mq[$];      // requests accepted but not yet popped
   mreq_t      act;        // request currently on the bus / waiting
   bit         active;
   bit         in_reset;
   int         cyc;        // index of the most recent rising edge
   int         t_start;    // edge at which act was popped
   int         next_pop;   // earliest edge a new pop may happen
   logic       exp_dv;
   logic [3:0] exp_dt;
   logic [1:0] exp_ds;

   int n_checks;
   int n_errors;

   logic [3:0] ops [10] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hC, 4'hF};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic bit is_wait_op(input logic [3:0] o);
      return (o == 4'h7) || (o == 4'hF);
   endfunction

   task automatic model_reset();
      mq.delete();
      active   = 1'b0;
      next_pop = 0;
      exp_dv   = 1'b0;
      exp_dt   = '0;
      exp_ds   = 2'b00;
   endtask

   task automatic complete(input logic [1:0] s);
      exp_dv   = 1'b1;
      exp_dt   = act.t;
      exp_ds   = s;
      active   = 1'b0;
      next_pop = cyc + 2;   // one REPORT cycle, then IDLE pops
   endtask

   // Advance the model across rising edge 'cyc' using the stimulus at that edge.
   task automatic model_step();
      bit pushed;
      exp_dv = 1'b0;
      if (in_reset) return;
      pushed = bus.req_valid && (mq.size() < DEPTH);
      if (active) begin
         if (!is_wait_op(act.o)) begin
            if (cyc == t_start + HOLD) complete(2'b00);
         end else if (cyc >= t_start + HOLD + 1) begin
            if (flags[act.t] == (act.o == 4'h7)) complete(2'b00);
            else if (TO_EN && cyc == t_start + HOLD + TMO) complete(2'b01);
         end
      end else if (mq.size() > 0 && cyc >= next_pop) begin
         act     = mq.pop_front();
         t_start = cyc;
         if (act.t >= NUM_TASKS) begin
            exp_dv   = 1'b1;
            exp_dt   = act.t;
            exp_ds   = 2'b10;
            next_pop = cyc + 2;
         end else begin
            active = 1'b1;
         end
      end
      if (pushed) mq.push_back('{t: bus.req_task, o: bus.req_opcode, d: bus.req_data});
   endtask

   // One clock: model steps on the rising edge, outputs compared on the falling.
   task automatic tick();
      logic [15:0] exp_op;
      bit          exp_busy;
      @(posedge CLK);
      cyc++;
      model_step();
      @(negedge CLK);
      exp_op   = (!in_reset && active && (cyc - t_start) < HOLD) ?
                 {4'h0, act.t, act.o, act.d} : 16'h0000;
      exp_busy = !in_reset && (active || mq.size() > 0 || cyc < next_pop - 1);
      check("req_ready",   bus.req_ready,   mq.size() < DEPTH);
      check("out_op",      bus.out_op,      exp_op);
      check("done_valid",  bus.done_valid,  exp_dv);
      check("done_task",   bus.done_task,   exp_dt);
      check("done_status", bus.done_status, exp_ds);
      check("busy",        bus.busy,        exp_busy);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send(input logic [3:0] t, input logic [3:0] o, input logic [3:0] d);
      bit acc;
      int g;
      g              = 0;
      bus.req_valid  = 1'b1;
      bus.req_task   = t;
      bus.req_opcode = o;
      bus.req_data   = d;
      do begin
         acc = (mq.size() < DEPTH);
         tick();
         g++;
      end while (!acc && g < 200);
      check("send_accept", acc, 1);
      bus.req_valid = 1'b0;
   endtask

   task automatic random_flag_toggle();
      if ($urandom_range(0, 5) == 0) flags[$urandom_range(0, NUM_TASKS - 1)] ^= 1'b1;
   endtask

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   initial begin
      int guard;
      n_checks       = 0;
      n_errors       = 0;
      cyc            = 0;
      flags          = '0;
      bus.req_valid  = 1'b0;
      bus.req_task   = '0;
      bus.req_opcode = '0;
      bus.req_data   = '0;
      in_reset       = 1'b1;
      model_reset();

      // Reset state
      idle(2);
      RST_N    = 1'b1;
      in_reset = 1'b0;
      idle(2);

      // Single ready op: 16'h0410 for HOLD cycles
      send(4'd4, 4'h1, 4'h0);
      idle(8);

      // Execute handshake: flag rises 10 cycles after WAIT entry
      flags[4] = 1'b0;
      send(4'd4, 4'h7, 4'h3);
      idle(13);
      flags[4] = 1'b1;
      idle(6);

      // Finish with flag stuck high: timeout, or blocking until it drops
      flags[2] = 1'b1;
      send(4'd2, 4'hF, 4'h0);
      idle(25);
      flags[2] = 1'b0;
      idle(5);

      // Bad ID, plus the boundary IDs on either side of the limit
      send(4'd9, 4'h1, 4'h2);
      idle(5);
      send(4'd8, 4'h5, 4'h1);
      send(4'd7, 4'h6, 4'hA);
      idle(8);

      // FIFO full / back-to-back, including opcode 0 and a stalled push
      send(4'd0, 4'h1, 4'h1);
      send(4'd1, 4'h2, 4'h2);
      send(4'd3, 4'h5, 4'h3);
      send(4'd5, 4'h0, 4'h4);
      send(4'd6, 4'hC, 4'h5);
      send(4'd7, 4'h3, 4'h6);
      idle(30);

      // Randomized mix
      for (int i = 0; i < 600; i++) begin
         random_flag_toggle();
         bus.req_valid  = ($urandom_range(0, 2) == 0);
         bus.req_task   = 4'($urandom_range(0, 11));
         bus.req_opcode = ops[$urandom_range(0, 9)];
         bus.req_data   = 4'($urandom);
         tick();
      end
      bus.req_valid = 1'b0;
      guard = 0;
      while ((active || mq.size() > 0 || cyc < next_pop) && guard < 3000) begin
         random_flag_toggle();
         tick();
         guard++;
      end
      check("drain_bound", guard < 3000, 1);
      idle(3);

      // Reset in the middle of WAIT with another request queued
      flags[3] = 1'b0;
      send(4'd3, 4'h7, 4'h5);
      idle(5);
      send(4'd1, 4'h1, 4'h1);
      idle(1);
      RST_N    = 1'b0;
      in_reset = 1'b1;
      model_reset();
      #1;
      check("rst_out_op",     bus.out_op,     16'h0000);
      check("rst_busy",       bus.busy,       0);
      check("rst_done_valid", bus.done_valid, 0);
      check("rst_req_ready",  bus.req_ready,  1);
      idle(2);
      RST_N    = 1'b1;
      in_reset = 1'b0;
      idle(10);

      // One more op after reset to show the issuer restarts cleanly
      send(4'd2, 4'h1, 4'h7);
      idle(8);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
